mem_wb_pipe: RTL and testbench

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

---
 rtl/mem_wb_pipe_pkg.sv | 26 ++
 rtl/mem_wb_pipe_entry_reg.sv | 30 +++
 rtl/mem_wb_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_mem_wb_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pipe_pkg.sv
// Shared MEM/WB pipeline definitions: occupancy states, width defaults and
// the payload carried from the memory stage to writeback.
package mem_wb_pipe_pkg;

  localparam int XLEN_DEF = 64;
  localparam int RD_W_DEF = 5;

  // Occupancy of the stage: nothing held, main register only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

  // One MEM/WB entry at the default widths.
  typedef struct packed {
    logic [XLEN_DEF-1:0] mem_data;
    logic [XLEN_DEF-1:0] alu_result;
    logic [XLEN_DEF-1:0] pc;
    logic [RD_W_DEF-1:0] rd;
    logic                reg_write;
    logic                mem_to_reg;
    logic                jump;
  } mem_wb_payload_t;

endpackage

// File: rtl/mem_wb_pipe_entry_reg.sv
// One held pipeline entry: loads a full payload when enabled, otherwise keeps
// its contents. Cleared to zero on reset so every head output reads zero.
module pipe_entry_reg
  import mem_wb_pipe_pkg::*;
#(
  parameter type payload_t = mem_wb_payload_t
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  payload_t d,
  output payload_t q
);

  payload_t q_r;

  // Payload storage: clear on reset, capture on load, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with valid/ready handshakes. SKID_EN=1 gives a
// two-entry skid buffer whose in_ready is registered (no out_ready->in_ready
// path); SKID_EN=0 gives a single entry with a combinational in_ready.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RD_W    = RD_W_DEF,
  parameter int SKID_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] mem_data_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [RD_W-1:0] rd_in,
  input  logic            RegWrite_in,
  input  logic            MemtoReg_in,
  input  logic            Jump_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] mem_data_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] pc_out,
  output logic [RD_W-1:0] rd_out,
  output logic            RegWrite_out,
  output logic            MemtoReg_out,
  output logic            Jump_out,
  output logic [XLEN-1:0] wb_data_out
);

  // Payload layout at this instance's widths (same field order as the package type).
  typedef struct packed {
    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc;
    logic [RD_W-1:0] rd;
    logic            reg_write;
    logic            mem_to_reg;
    logic            jump;
  } payload_t;

  pipe_state_t state_r;
  pipe_state_t next_state_s;
  payload_t    in_pay_s;
  payload_t    main_d_s;
  payload_t    main_q_s;
  payload_t    skid_q_s;
  logic        main_load_s;
  logic        skid_load_s;
  logic        accept_s;
  logic        retire_s;
  logic        in_ready_s;
  logic        out_valid_s;

  assign in_pay_s = '{mem_data:   mem_data_in,
                      alu_result: alu_result_in,
                      pc:         pc_in,
                      rd:         rd_in,
                      reg_write:  RegWrite_in,
                      mem_to_reg: MemtoReg_in,
                      jump:       Jump_in};

  assign out_valid_s = (state_r != ST_EMPTY);
  assign accept_s    = in_valid & in_ready_s;
  assign retire_s    = out_valid_s & out_ready;

  generate
    if (SKID_EN != 0) begin : g_skid_ready
      logic in_ready_r;

      // Registered ready: stage can take another entry unless it will be full.
      always_ff @(posedge clk) begin
        if (reset) begin
          in_ready_r <= 1'b1;
        end else begin
          in_ready_r <= (next_state_s != ST_TWO);
        end
      end

      assign in_ready_s = in_ready_r;
    end else begin : g_single_ready
      assign in_ready_s = ~out_valid_s | out_ready;
    end
  endgenerate

  // State register: occupancy of main/skid entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; flush empties the stage and discards a same-cycle accept.
  always_comb begin
    next_state_s = state_r;
    if (flush) begin
      next_state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            next_state_s = ST_ONE;
          end else begin
            next_state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && retire_s) begin
            next_state_s = ST_ONE;
          end else if (accept_s) begin
            next_state_s = (SKID_EN != 0) ? ST_TWO : ST_ONE;
          end else if (retire_s) begin
            next_state_s = ST_EMPTY;
          end else begin
            next_state_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (retire_s) begin
            next_state_s = ST_ONE;
          end else begin
            next_state_s = ST_TWO;
          end
        end
        default: begin
          next_state_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Load enables: main takes the new entry (or the skid entry when draining TWO).
  always_comb begin
    main_load_s = 1'b0;
    skid_load_s = 1'b0;
    main_d_s    = in_pay_s;
    if (flush) begin
      main_load_s = 1'b0;
      skid_load_s = 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          main_load_s = accept_s;
        end
        ST_ONE: begin
          main_load_s = accept_s & retire_s;
          skid_load_s = accept_s & ~retire_s & (SKID_EN != 0);
        end
        ST_TWO: begin
          main_load_s = retire_s;
          main_d_s    = skid_q_s;
        end
        default: begin
          main_load_s = 1'b0;
          skid_load_s = 1'b0;
        end
      endcase
    end
  end

  pipe_entry_reg #(.payload_t(payload_t)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load_s),
    .d     (main_d_s),
    .q     (main_q_s)
  );

  pipe_entry_reg #(.payload_t(payload_t)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load_s),
    .d     (in_pay_s),
    .q     (skid_q_s)
  );

  assign in_ready       = in_ready_s;
  assign out_valid      = out_valid_s;
  assign mem_data_out   = main_q_s.mem_data;
  assign alu_result_out = main_q_s.alu_result;
  assign pc_out         = main_q_s.pc;
  assign rd_out         = main_q_s.rd;
  assign MemtoReg_out   = main_q_s.mem_to_reg;
  assign Jump_out       = main_q_s.jump;
  // Writes to x0 and empty heads never reach the register file.
  assign RegWrite_out   = main_q_s.reg_write & out_valid_s & (main_q_s.rd != {RD_W{1'b0}});

  // Writeback select: jump link address, then load data, then ALU result.
  always_comb begin
    wb_data_out = main_q_s.alu_result;
    if (main_q_s.jump) begin
      wb_data_out = main_q_s.pc + {{(XLEN-3){1'b0}}, 3'd4};
    end else if (main_q_s.mem_to_reg) begin
      wb_data_out = main_q_s.mem_data;
    end else begin
      wb_data_out = main_q_s.alu_result;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe: skid instance checked by a monitor that
// pops expected entries on every retire; single-entry instance checked directly.
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [63:0] mem_data_in, alu_result_in, pc_in;
  logic [4:0]  rd_in;
  logic        RegWrite_in, MemtoReg_in, Jump_in;

  logic        in_ready, out_valid, RegWrite_out, MemtoReg_out, Jump_out;
  logic [63:0] mem_data_out, alu_result_out, pc_out, wb_data_out;
  logic [4:0]  rd_out;

  logic        in_ready0, out_valid0, RegWrite_out0, MemtoReg_out0, Jump_out0;
  logic [63:0] mem_data_out0, alu_result_out0, pc_out0, wb_data_out0;
  logic [4:0]  rd_out0;

  typedef struct {
    logic [63:0] wb;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_wb_pipe #(.XLEN(64), .RD_W(5), .SKID_EN(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mem_data_in(mem_data_in), .alu_result_in(alu_result_in), .pc_in(pc_in), .rd_in(rd_in),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Jump_in(Jump_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mem_data_out(mem_data_out), .alu_result_out(alu_result_out), .pc_out(pc_out),
    .rd_out(rd_out), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .Jump_out(Jump_out), .wb_data_out(wb_data_out)
  );

  mem_wb_pipe #(.XLEN(64), .RD_W(5), .SKID_EN(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .mem_data_in(mem_data_in), .alu_result_in(alu_result_in), .pc_in(pc_in), .rd_in(rd_in),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Jump_in(Jump_in),
    .out_valid(out_valid0), .out_ready(out_ready),
    .mem_data_out(mem_data_out0), .alu_result_out(alu_result_out0), .pc_out(pc_out0),
    .rd_out(rd_out0), .RegWrite_out(RegWrite_out0), .MemtoReg_out(MemtoReg_out0),
    .Jump_out(Jump_out0), .wb_data_out(wb_data_out0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [63:0] mem, input logic [63:0] alu, input logic [63:0] pc,
                        input logic [4:0] rd, input logic rw, input logic mtr, input logic j);
    in_valid      = 1'b1;
    mem_data_in   = mem;
    alu_result_in = alu;
    pc_in         = pc;
    rd_in         = rd;
    RegWrite_in   = rw;
    MemtoReg_in   = mtr;
    Jump_in       = j;
  endtask

  // Offer an entry for one edge; when push is set the entry is known to be accepted.
  task automatic send(input logic [63:0] mem, input logic [63:0] alu, input logic [63:0] pc,
                      input logic [4:0] rd, input logic rw, input logic mtr, input logic j,
                      input bit push);
    exp_t e;
    set_in(mem, alu, pc, rd, rw, mtr, j);
    if (push) begin
      e.wb = j ? (pc + 64'd4) : (mtr ? mem : alu);
      e.pc = pc;
      e.rd = rd;
      e.rw = rw && (rd != 5'd0);
      exp_q.push_back(e);
    end
    tick();
  endtask

  // Monitor: every retire of the skid instance is compared against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_retire_rd", {59'd0, rd_out}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("head_rd", {59'd0, rd_out}, {59'd0, e.rd});
        chk("head_wb", wb_data_out, e.wb);
        chk("head_pc", pc_out, e.pc);
        chk("head_regwrite", {63'd0, RegWrite_out}, {63'd0, e.rw});
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mem_data_in = 64'd0; alu_result_in = 64'd0; pc_in = 64'd0; rd_in = 5'd0;
    RegWrite_in = 1'b0; MemtoReg_in = 1'b0; Jump_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_regwrite", {63'd0, RegWrite_out}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_wb", wb_data_out, 64'd0);
    chk("rst0_in_ready", {63'd0, in_ready0}, 64'd1);
    tick();

    // Basic ALU writeback, one-cycle latency.
    out_ready = 1'b1;
    send(64'd0, 64'h10, 64'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_out_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_rd", {59'd0, rd_out}, 64'd3);
    tick();

    // Back-to-back streaming: jump wrap, load data, jump priority, write to x0.
    send(64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    send(64'hAAAA, 64'h5, 64'h40, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    send(64'h9999, 64'h7, 64'h100, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1);
    send(64'h0, 64'h55, 64'h200, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("x0_out_valid", {63'd0, out_valid}, 64'd1);
    chk("x0_regwrite", {63'd0, RegWrite_out}, 64'd0);
    tick();
    tick();

    // Backpressure: A and B held, C stalled, then all drain in order.
    out_ready = 1'b0;
    send(64'h0, 64'hA1, 64'h300, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
    send(64'h0, 64'hB2, 64'h304, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
    set_in(64'h0, 64'hC3, 64'h308, 5'd12, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("full_head_rd", {59'd0, rd_out}, 64'd10);
    tick();
    @(negedge clk);
    chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    chk("hold_head_alu", alu_result_out, 64'hA1);
    tick();
    out_ready = 1'b1;
    begin
      exp_t e;
      e.wb = 64'hC3; e.pc = 64'h308; e.rd = 5'd12; e.rw = 1'b1;
      exp_q.push_back(e);
    end
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
    tick();

    // Flush in the full state discards both held entries and the offered one.
    out_ready = 1'b0;
    send(64'h0, 64'hD4, 64'h400, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
    send(64'h0, 64'hE5, 64'h404, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0);
    set_in(64'h0, 64'hF6, 64'h408, 5'd15, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    @(negedge clk);
    chk("flush_stays_empty", {63'd0, out_valid}, 64'd0);
    tick();
    out_ready = 1'b1;
    send(64'h0, 64'h77, 64'h500, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    tick();
    tick();

    // Reset while full (both instances), including the single-entry ready rule.
    out_ready = 1'b0;
    send(64'h1111, 64'h2222, 64'h3330, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    set_in(64'h4444, 64'h5555, 64'h6660, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    chk("single_ready_blocked", {63'd0, in_ready0}, 64'd0);
    out_ready = 1'b1;
    #1;
    chk("single_ready_passthru", {63'd0, in_ready0}, 64'd1);
    out_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("two_in_ready", {63'd0, in_ready}, 64'd0);
    chk("two_head_wb", wb_data_out, 64'h3334);
    chk("single_head_rd", {59'd0, rd_out0}, 64'd7);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_mem", mem_data_out, 64'd0);
    chk("mid_rst_alu", alu_result_out, 64'd0);
    chk("mid_rst_pc", pc_out, 64'd0);
    chk("mid_rst_wb", wb_data_out, 64'd0);
    chk("mid_rst_ctrl", {56'd0, rd_out, RegWrite_out, MemtoReg_out, Jump_out}, 64'd0);
    chk("mid_rst0_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("mid_rst0_in_ready", {63'd0, in_ready0}, 64'd1);
    chk("mid_rst0_fields", mem_data_out0 | alu_result_out0 | pc_out0 | wb_data_out0, 64'd0);
    chk("mid_rst0_ctrl", {56'd0, rd_out0, RegWrite_out0, MemtoReg_out0, Jump_out0}, 64'd0);
    tick();
    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
